// File: rtl/adder_sub_acc_n_bits.sv
// Chunk-serial add/subtract/accumulate unit: W bits of the N-bit operands per clock,
// with signed overflow detection, optional saturation and a Start/Busy/Done handshake.
module adder_sub_acc_n_bits #(
    parameter int N   = 8,
    parameter int W   = 4,
    parameter int SAT = 0
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] A,
    input  logic         LoadB,
    input  logic         Start,
    input  logic [1:0]   Op,
    output logic [N-1:0] B,
    output logic [N-1:0] S,
    output logic         Carry,
    output logic         Overflow,
    output logic         Busy,
    output logic         Done
);

    localparam int K  = N / W;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, nxt;
    logic signed [N-1:0]   x_reg, y_reg;
    logic        [N-1:0]   part;
    logic                  sub_reg;
    logic                  c_reg;
    logic        [IW-1:0]  idx;

    logic        [W-1:0]   xc, yc;
    logic        [W:0]     sum;
    logic                  last;
    logic                  ovf_last;
    logic        [N-1:0]   res_full;

    // Clamp to the signed range on overflow; the direction follows the sign of X.
    function automatic logic [N-1:0] saturate(input logic [N-1:0] v,
                                              input logic ovf,
                                              input logic neg);
        logic signed [N-1:0] lim;
        if (SAT != 0 && ovf)
            lim = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            lim = v;
        return lim;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (Start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

    // Current chunk; the final chunk is merged straight into the result so S updates on the DONE edge.
    always_comb begin
        xc       = x_reg[idx*W +: W];
        yc       = y_reg[idx*W +: W] ^ {W{sub_reg}};
        sum      = {1'b0, xc} + {1'b0, yc} + {{W{1'b0}}, c_reg};
        last     = (idx == IW'(K - 1));
        ovf_last = (xc[W-1] == yc[W-1]) && (sum[W-1] != xc[W-1]);
        res_full = part;
        res_full[idx*W +: W] = sum[W-1:0];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_reg    <= '0;
            y_reg    <= '0;
            part     <= '0;
            sub_reg  <= 1'b0;
            c_reg    <= 1'b0;
            idx      <= '0;
            B        <= '0;
            S        <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LoadB) B <= A;
                    if (Start) begin
                        x_reg   <= Op[1] ? S : A;
                        y_reg   <= Op[1] ? A : B;
                        sub_reg <= Op[0];
                        c_reg   <= Op[0];
                        idx     <= '0;
                    end
                end
                RUN: begin
                    part[idx*W +: W] <= sum[W-1:0];
                    c_reg            <= sum[W];
                    idx              <= idx + 1'b1;
                    if (last) begin
                        S        <= saturate(res_full, ovf_last, xc[W-1]);
                        Carry    <= sum[W];
                        Overflow <= ovf_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sub_acc_n_bits.sv
// Bench for adder_sub_acc_n_bits: a wrapping and a saturating N=8/W=4 instance driven in lockstep
// and compared against an integer-arithmetic reference model.
module tb_adder_sub_acc_n_bits;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] A     = '0;
    logic       LoadB = 1'b0;
    logic       Start = 1'b0;
    logic [1:0] Op    = '0;

    logic [7:0] B0, S0, B1, S1;
    logic       C0, V0, Busy0, Done0, C1, V1, Busy1, Done1;

    always #5 Clock = ~Clock;

    adder_sub_acc_n_bits #(.N(8), .W(4), .SAT(0)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .A(A), .LoadB(LoadB), .Start(Start), .Op(Op),
        .B(B0), .S(S0), .Carry(C0), .Overflow(V0), .Busy(Busy0), .Done(Done0));

    adder_sub_acc_n_bits #(.N(8), .W(4), .SAT(1)) dut_sat (
        .Clock(Clock), .Reset(Reset), .A(A), .LoadB(LoadB), .Start(Start), .Op(Op),
        .B(B1), .S(S1), .Carry(C1), .Overflow(V1), .Busy(Busy1), .Done(Done1));

    int total = 0;
    int bad   = 0;

    logic [7:0] m_b, m_s0, m_s1;
    logic       e_c0, e_v0, e_c1, e_v1;

    int busy_n, done_at;
    bit unstable;

    // Reference: plain integer add/subtract, unsigned carry, signed-range overflow.
    task automatic model_step(input logic [1:0] op, input logic [7:0] a, input bit sat,
                              input logic [7:0] s_in, input logic [7:0] b_in,
                              output logic [7:0] s_out, output logic c, output logic ov);
        int x, y, sx, sy, u, sv;
        x  = op[1] ? int'(s_in) : int'(a);
        y  = op[1] ? int'(a) : int'(b_in);
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        if (!op[0]) begin
            u = x + y;  c = (u > 255); sv = sx + sy;
        end else begin
            u = x - y;  c = (x >= y);  sv = sx - sy;
        end
        ov    = (sv > 127) || (sv < -128);
        s_out = 8'(u & 255);
        if (sat && ov) s_out = (sv > 127) ? 8'h7F : 8'h80;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] a, input bit loadb);
        logic [7:0] n0, n1;
        model_step(op, a, 1'b0, m_s0, m_b, n0, e_c0, e_v0);
        model_step(op, a, 1'b1, m_s1, m_b, n1, e_c1, e_v1);
        m_s0 = n0;
        m_s1 = n1;
        if (loadb) m_b = a;
    endtask

    task automatic load_b(input logic [7:0] v);
        @(negedge Clock);
        A = v; LoadB = 1'b1;
        @(negedge Clock);
        LoadB = 1'b0;
        m_b = v;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        m_b = '0; m_s0 = '0; m_s1 = '0;
    endtask

    // Issue one operation and follow it until Done; returns at the negedge where Done is high.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input bit loadb,
                          output int nbusy, output int dat, output bit unst);
        logic [7:0] p0, p1;
        @(negedge Clock);
        p0 = S0; p1 = S1;
        model_apply(op, a, loadb);
        A = a; Op = op; Start = 1'b1; LoadB = loadb;
        nbusy = 0; dat = 0; unst = 1'b0;
        @(negedge Clock);
        Start = 1'b0; LoadB = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (Done0) begin
                dat = i;
                break;
            end
            if (Busy0) nbusy++;
            if (S0 !== p0 || S1 !== p1) unst = 1'b1;
            @(negedge Clock);
        end
    endtask

    task automatic check_op(input string name);
        total++;
        if (done_at !== 3 || busy_n !== 2) begin
            bad++;
            $display("FAIL %s timing: got busy=%0d done_at=%0d want busy=2 done_at=3", name, busy_n, done_at);
        end
        total++;
        if (unstable !== 1'b0) begin
            bad++;
            $display("FAIL %s stable: S changed during RUN", name);
        end
        total++;
        if ({S0, C0, V0} !== {m_s0, e_c0, e_v0}) begin
            bad++;
            $display("FAIL %s wrap: got S=%h C=%b V=%b want S=%h C=%b V=%b", name, S0, C0, V0, m_s0, e_c0, e_v0);
        end
        total++;
        if ({S1, C1, V1} !== {m_s1, e_c1, e_v1}) begin
            bad++;
            $display("FAIL %s sat: got S=%h C=%b V=%b want S=%h C=%b V=%b", name, S1, C1, V1, m_s1, e_c1, e_v1);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; A = 8'hAA; LoadB = 1'b1; Start = 1'b1; Op = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            total++;
            if ((Busy0 | Busy1) !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy: got busy=%b%b want 00", Busy0, Busy1);
            end
        end
        total++;
        if ({B0, S0, C0, V0, Busy0, Done0, B1, S1, C1, V1, Busy1, Done1} !== '0) begin
            bad++;
            $display("FAIL reset_state: got B=%h S=%h C=%b V=%b busy=%b done=%b want all 0",
                     B0, S0, C0, V0, Busy0, Done0);
        end
        Reset = 1'b0; LoadB = 1'b0; Start = 1'b0;
        m_b = '0; m_s0 = '0; m_s1 = '0;
        @(negedge Clock);
        total++;
        if ((Busy0 | Done0) !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got busy=%b done=%b want 0 0", Busy0, Done0);
        end
    endtask

    task automatic test_add();
        load_b(8'h05);
        total++;
        if (B0 !== 8'h05) begin
            bad++;
            $display("FAIL loadb: got B=%h want 05", B0);
        end
        run_op(2'b00, 8'h03, 1'b0, busy_n, done_at, unstable);
        check_op("add_5_3");
        total++;
        if ({S0, C0, V0} !== {8'h08, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_const: got S=%h C=%b V=%b want S=08 C=0 V=0", S0, C0, V0);
        end
    endtask

    task automatic test_overflow();
        load_b(8'h80);
        run_op(2'b00, 8'h80, 1'b0, busy_n, done_at, unstable);
        check_op("ovf_neg");
        total++;
        if ({S0, C0, V0, S1, V1} !== {8'h00, 1'b1, 1'b1, 8'h80, 1'b1}) begin
            bad++;
            $display("FAIL ovf_neg_const: got S=%h C=%b V=%b Ssat=%h Vsat=%b want 00 1 1 80 1", S0, C0, V0, S1, V1);
        end
        load_b(8'h7F);
        run_op(2'b00, 8'h01, 1'b0, busy_n, done_at, unstable);
        check_op("ovf_pos");
        total++;
        if ({S0, V0, S1, V1} !== {8'h80, 1'b1, 8'h7F, 1'b1}) begin
            bad++;
            $display("FAIL ovf_pos_const: got S=%h V=%b Ssat=%h Vsat=%b want 80 1 7f 1", S0, V0, S1, V1);
        end
    endtask

    task automatic test_subtract();
        load_b(8'h03);
        run_op(2'b01, 8'h05, 1'b0, busy_n, done_at, unstable);
        check_op("sub_5_3");
        total++;
        if ({S0, C0} !== {8'h02, 1'b1}) begin
            bad++;
            $display("FAIL sub_5_3_const: got S=%h C=%b want 02 1", S0, C0);
        end
        load_b(8'h05);
        run_op(2'b01, 8'h03, 1'b0, busy_n, done_at, unstable);
        check_op("sub_3_5");
        total++;
        if ({S0, C0, V0} !== {8'hFE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub_3_5_const: got S=%h C=%b V=%b want fe 0 0", S0, C0, V0);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] want [3] = '{8'h10, 8'h20, 8'h30};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_op(2'b10, 8'h10, 1'b0, busy_n, done_at, unstable);
            check_op("acc_add");
            total++;
            if (S0 !== want[i]) begin
                bad++;
                $display("FAIL acc_step%0d: got S=%h want %h", i, S0, want[i]);
            end
        end
        run_op(2'b11, 8'h40, 1'b0, busy_n, done_at, unstable);
        check_op("acc_sub");
        total++;
        if ({S0, C0} !== {8'hF0, 1'b0}) begin
            bad++;
            $display("FAIL acc_sub_const: got S=%h C=%b want f0 0", S0, C0);
        end
    endtask

    task automatic test_ignore_busy();
        int extra_done, busy_seen, dat;
        load_b(8'h21);
        @(negedge Clock);
        model_apply(2'b00, 8'h04, 1'b0);
        A = 8'h04; Op = 2'b00; Start = 1'b1;
        @(negedge Clock);
        A = 8'h99; LoadB = 1'b1;
        @(negedge Clock);
        Start = 1'b0; LoadB = 1'b0;
        dat = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done0) begin
                dat = i + 1;
                break;
            end
            @(negedge Clock);
        end
        total++;
        if (dat !== 2) begin
            bad++;
            $display("FAIL ignore_done_time: got done_at=%0d want 2", dat);
        end
        Start = 1'b1; LoadB = 1'b1;
        @(negedge Clock);
        Start = 1'b0; LoadB = 1'b0;
        extra_done = 0; busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done0) extra_done++;
            if (Busy0) busy_seen++;
            @(negedge Clock);
        end
        total++;
        if (extra_done !== 0 || busy_seen !== 0) begin
            bad++;
            $display("FAIL ignore_queue: got extra_done=%0d busy=%0d want 0 0", extra_done, busy_seen);
        end
        total++;
        if ({B0, S0, C0, V0} !== {m_b, m_s0, e_c0, e_v0}) begin
            bad++;
            $display("FAIL ignore_result: got B=%h S=%h C=%b V=%b want B=%h S=%h C=%b V=%b",
                     B0, S0, C0, V0, m_b, m_s0, e_c0, e_v0);
        end
    endtask

    task automatic test_reset_run();
        int done_seen;
        @(negedge Clock);
        A = 8'h07; Op = 2'b00; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0; Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        m_b = '0; m_s0 = '0; m_s1 = '0;
        total++;
        if ({S0, B0, Busy0, S1} !== '0) begin
            bad++;
            $display("FAIL reset_run_state: got S=%h B=%h busy=%b Ssat=%h want 0", S0, B0, Busy0, S1);
        end
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (Done0 | Done1) done_seen++;
            @(negedge Clock);
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL reset_run_done: got done pulses=%0d want 0", done_seen);
        end
    endtask

    task automatic test_simultaneous();
        load_b(8'h11);
        run_op(2'b00, 8'h22, 1'b1, busy_n, done_at, unstable);
        check_op("simul");
        total++;
        if ({S0, B0} !== {8'h33, 8'h22}) begin
            bad++;
            $display("FAIL simul_const: got S=%h B=%h want 33 22", S0, B0);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] a;
        bit         lb;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load_b(8'($urandom));
            op = 2'($urandom);
            a  = 8'($urandom);
            lb = 1'($urandom_range(0, 1));
            run_op(op, a, lb, busy_n, done_at, unstable);
            check_op("random");
            total++;
            if (B0 !== m_b) begin
                bad++;
                $display("FAIL random_b: got B=%h want %h", B0, m_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_accumulate();
        test_ignore_busy();
        test_reset_run();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
